// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and types shared by the pipeline-register slice.
//   - Opcode field values (instr[31:27]) and ALU op values (instr[6:2])
//   - Default bubble word
//   - Multdiv sequencer state enum
//   - is_multdiv(): recognises a mul/div R-type instruction
package pipe_pkg;

    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_JAL  = 5'd3;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21;
    localparam logic [4:0] OP_BEX  = 5'd22;

    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Opcode in [31:27], ALU op in [6:2].
    function automatic logic is_multdiv(input logic [31:0] instr);
        return (instr[31:27] == OP_ALU) &&
               ((instr[6:2] == ALU_MUL) || (instr[6:2] == ALU_DIV));
    endfunction

endpackage

// File: rtl/pipe_latch.sv
// pipe_latch: one 32-bit pipeline instruction register.
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset, loads NOP_INSTR
//   en       - capture d when high
//   bubble   - load NOP_INSTR (wins over en)
//   d / q    - instruction in / out
module pipe_latch
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        en,
    input  logic        bubble,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    q <= NOP_INSTR;
        else if (bubble) q <= NOP_INSTR;
        else if (en)     q <= d;
    end

endmodule

// File: rtl/instr_pipeline_regs.sv
// instr_pipeline_regs: FD/DX/XM/WB instruction latches, XM/WB error flags,
// PC enable and an optional multdiv sequencer.
//
// Build option: define MULTDIV_EN to decode mul/div in DX and run the
// IDLE/BUSY sequencer. Without it, md_start/md_busy are tied low and
// md_rdy/md_exception are ignored (ports remain).
//
// Ports:
//   clock, reset_n          clock, async active-low reset
//   imem_instr              fetched instruction
//   load_use_stall          hold PC/FD, bubble into DX
//   branch_flush            squash FD and DX (overrides stall)
//   x_error                 overflow flag of the instruction in X
//   md_rdy, md_exception    multdiv completion and error
//   fd/dx/xm/wb_instr       stage instruction latches
//   xm_err, wb_err          stage error flags
//   pc_en                   PC write enable (combinational)
//   md_start                one-cycle multdiv start (combinational)
//   md_busy                 sequencer in BUSY
//
// Priority in IDLE: flush > multdiv start > load-use stall. A mul/div in DX
// must not be pushed into XM by a stall bubble, and a flush squashes it.
module instr_pipeline_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR  = NOP_DEFAULT,
    parameter int          MD_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] imem_instr,
    input  logic        load_use_stall,
    input  logic        branch_flush,
    input  logic        x_error,
    input  logic        md_rdy,
    input  logic        md_exception,
    output logic [31:0] fd_instr,
    output logic [31:0] dx_instr,
    output logic [31:0] xm_instr,
    output logic [31:0] wb_instr,
    output logic        xm_err,
    output logic        wb_err,
    output logic        pc_en,
    output logic        md_start,
    output logic        md_busy
);

    logic fd_en, dx_en;
    logic fd_bub, dx_bub, xm_bub;
    logic xm_err_d;

    pipe_latch #(.NOP_INSTR(NOP_INSTR)) u_fd (
        .clock(clock), .reset_n(reset_n), .en(fd_en), .bubble(fd_bub),
        .d(imem_instr), .q(fd_instr));

    pipe_latch #(.NOP_INSTR(NOP_INSTR)) u_dx (
        .clock(clock), .reset_n(reset_n), .en(dx_en), .bubble(dx_bub),
        .d(fd_instr), .q(dx_instr));

    pipe_latch #(.NOP_INSTR(NOP_INSTR)) u_xm (
        .clock(clock), .reset_n(reset_n), .en(1'b1), .bubble(xm_bub),
        .d(dx_instr), .q(xm_instr));

    // WB always advances.
    pipe_latch #(.NOP_INSTR(NOP_INSTR)) u_wb (
        .clock(clock), .reset_n(reset_n), .en(1'b1), .bubble(1'b0),
        .d(xm_instr), .q(wb_instr));

`ifdef MULTDIV_EN
    localparam logic [6:0] TMO_LAST = 7'(MD_TIMEOUT - 1);

    md_state_e  state, state_d;
    logic [6:0] cnt, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= MD_IDLE;
            cnt   <= 7'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    assign md_busy = (state == MD_BUSY);
`else
    assign md_start = 1'b0;
    assign md_busy  = 1'b0;

    logic unused_md;
    assign unused_md = md_rdy ^ md_exception ^ (MD_TIMEOUT == 0);
`endif

    always_comb begin
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        fd_bub   = 1'b0;
        dx_bub   = 1'b0;
        xm_bub   = 1'b0;
        pc_en    = 1'b1;
        xm_err_d = x_error;
`ifdef MULTDIV_EN
        md_start = 1'b0;
        state_d  = state;
        cnt_d    = cnt;
        if (state == MD_BUSY) begin
            // Flush/stall are ignored here; completion is a plain advance.
            if (md_rdy) begin
                xm_err_d = md_exception;
                state_d  = MD_IDLE;
            end else if (cnt == TMO_LAST) begin
                xm_err_d = 1'b1;
                state_d  = MD_IDLE;
            end else begin
                fd_en    = 1'b0;
                dx_en    = 1'b0;
                xm_bub   = 1'b1;
                xm_err_d = 1'b0;
                pc_en    = 1'b0;
                cnt_d    = cnt + 7'd1;
            end
        end else if (branch_flush) begin
            fd_bub = 1'b1;
            dx_bub = 1'b1;
        end else if (is_multdiv(dx_instr)) begin
            md_start = 1'b1;
            fd_en    = 1'b0;
            dx_en    = 1'b0;
            xm_bub   = 1'b1;
            xm_err_d = 1'b0;
            pc_en    = 1'b0;
            state_d  = MD_BUSY;
            cnt_d    = 7'd0;
        end else if (load_use_stall) begin
            fd_en  = 1'b0;
            dx_bub = 1'b1;
            pc_en  = 1'b0;
        end
`else
        if (branch_flush) begin
            fd_bub = 1'b1;
            dx_bub = 1'b1;
        end else if (load_use_stall) begin
            fd_en  = 1'b0;
            dx_bub = 1'b1;
            pc_en  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xm_err <= 1'b0;
            wb_err <= 1'b0;
        end else begin
            xm_err <= xm_err_d;
            wb_err <= xm_err;
        end
    end

endmodule

// File: tb/tb_instr_pipeline_regs.sv
// Scoreboard bench for instr_pipeline_regs. The driver issues one cycle of
// stimulus, pushes the expected per-cycle view from a stage-list reference
// model, and a monitor on the falling edge pops and compares.
module tb_instr_pipeline_regs;

    localparam int          TMO = 8;
    localparam logic [31:0] NOP = 32'h0;
`ifdef MULTDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] imem_instr = '0;
    logic        load_use_stall = 1'b0, branch_flush = 1'b0, x_error = 1'b0;
    logic        md_rdy = 1'b0, md_exception = 1'b0;
    logic [31:0] fd_instr, dx_instr, xm_instr, wb_instr;
    logic        xm_err, wb_err, pc_en, md_start, md_busy;

    instr_pipeline_regs #(.MD_TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .imem_instr(imem_instr),
        .load_use_stall(load_use_stall), .branch_flush(branch_flush),
        .x_error(x_error), .md_rdy(md_rdy), .md_exception(md_exception),
        .fd_instr(fd_instr), .dx_instr(dx_instr), .xm_instr(xm_instr),
        .wb_instr(wb_instr), .xm_err(xm_err), .wb_err(wb_err),
        .pc_en(pc_en), .md_start(md_start), .md_busy(md_busy));

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0][31:0] st;
        logic xm_err, wb_err, pc_en, md_start, md_busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: stage list 0=FD,1=DX,2=XM,3=WB.
    logic [31:0] m_pipe [4];
    logic        m_xm_err, m_wb_err;
    bit          m_busy;
    int          m_elapsed;

    function automatic bit is_md(input logic [31:0] ins);
        return (ins[31:27] == 5'd0) && (ins[6:2] == 5'd6 || ins[6:2] == 5'd7);
    endfunction

    // Stages above k take their predecessor, stage k gets inject, stages
    // below k stay put.
    function automatic void advance(input int k, input logic [31:0] inject);
        for (int s = 3; s > k; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[k] = inject;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 5))
            0: begin ins[31:27] = 5'd0; ins[6:2] = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7; end
            1: ins[31:27] = 5'd8;
            2: begin ins[31:27] = 5'd0; ins[6:2] = 5'd0; end
            default: ;
        endcase
        return ins;
    endfunction

    function automatic exp_t snap(input bit start, input bit pce);
        exp_t e;
        for (int s = 0; s < 4; s++) e.st[s] = m_pipe[s];
        e.xm_err   = m_xm_err;
        e.wb_err   = m_wb_err;
        e.md_busy  = m_busy;
        e.md_start = start;
        e.pc_en    = pce;
        return e;
    endfunction

    task automatic do_reset();
        @(posedge clock); #1;
        reset_n = 1'b0;
        imem_instr = $urandom;
        load_use_stall = 0; branch_flush = 0; x_error = 0; md_rdy = 0; md_exception = 0;
        for (int s = 0; s < 4; s++) m_pipe[s] = NOP;
        m_xm_err = 0; m_wb_err = 0; m_busy = 0; m_elapsed = 0;
        sb_q.push_back(snap(1'b0, 1'b1));
    endtask

    task automatic step(input logic [31:0] ins, input bit st, input bit fl,
                        input bit xe, input bit rd, input bit ex);
        bit start, done, hold, pce;
        @(posedge clock); #1;
        reset_n = 1'b1;
        imem_instr = ins; load_use_stall = st; branch_flush = fl;
        x_error = xe; md_rdy = rd; md_exception = ex;

        start = MD_EN && !m_busy && !fl && is_md(m_pipe[1]);
        done  = m_busy && (rd || m_elapsed == TMO - 1);
        hold  = (m_busy && !done) || start;
        pce   = !(hold || (!m_busy && !fl && st));
        sb_q.push_back(snap(start, pce));

        m_wb_err = m_xm_err;
        if (hold) begin
            advance(2, NOP);
            m_xm_err = 1'b0;
            if (start) begin m_busy = 1; m_elapsed = 0; end
            else m_elapsed++;
        end else if (done) begin
            advance(0, ins);
            m_xm_err = rd ? ex : 1'b1;
            m_busy = 0;
        end else if (fl) begin
            advance(0, NOP);
            m_pipe[1] = NOP;
            m_xm_err = xe;
        end else if (st) begin
            advance(1, NOP);
            m_xm_err = xe;
        end else begin
            advance(0, ins);
            m_xm_err = xe;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(NOP, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("fd_instr", fd_instr, e.st[0]);
                chk("dx_instr", dx_instr, e.st[1]);
                chk("xm_instr", xm_instr, e.st[2]);
                chk("wb_instr", wb_instr, e.st[3]);
                chk("xm_err",   32'(xm_err),   32'(e.xm_err));
                chk("wb_err",   32'(wb_err),   32'(e.wb_err));
                chk("pc_en",    32'(pc_en),    32'(e.pc_en));
                chk("md_start", 32'(md_start), 32'(e.md_start));
                chk("md_busy",  32'(md_busy),  32'(e.md_busy));
            end
        end
    end

    initial begin : driver
        logic [31:0] mul_i, div_i, lw_i, add_i;
        mul_i = {5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd6, 2'b0};
        div_i = {5'd0, 5'd4, 5'd1, 5'd2, 5'd0, 5'd7, 2'b0};
        lw_i  = {5'd8, 5'd3, 5'd1, 17'd4};
        add_i = {5'd0, 5'd5, 5'd3, 5'd2, 5'd0, 5'd0, 2'b0};

        do_reset();

        // Load-use stall with lw in DX.
        step(lw_i, 0, 0, 0, 0, 0);
        step(add_i, 0, 0, 0, 0, 0);
        step(32'h1234_5678, 1, 0, 0, 0, 0);
        step(32'h1234_5678, 0, 0, 1, 0, 0);
        idle_steps(2);

        // Flush together with stall.
        step(32'h2000_0001, 0, 0, 0, 0, 0);
        step(32'h2000_0002, 0, 0, 0, 0, 0);
        step(32'h2000_0003, 1, 1, 0, 0, 0);
        idle_steps(3);

        // Mul completing on the 5th busy cycle with an exception.
        step(mul_i, 0, 0, 0, 0, 0);
        step(add_i, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(NOP, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 1, 1);
        idle_steps(3);

        // Div timing out, flush pulsed while busy.
        step(div_i, 0, 0, 0, 0, 0);
        step(add_i, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        for (int i = 0; i < TMO; i++) step(NOP, (i == 1), (i == 2), 1, 0, 0);
        idle_steps(3);

        // Back-to-back mul then div.
        step(mul_i, 0, 0, 0, 0, 0);
        step(div_i, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 1, 0);
        step(NOP, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 1, 0);
        idle_steps(3);

        // Reset while busy abandons the operation.
        step(mul_i, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        do_reset();
        idle_steps(4);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(rand_instr(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1);
        end

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_pipeline_regs.md
INSTR_PIPELINE_REGS -- requirements
Module: instr_pipeline_regs

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000, the word injected as a bubble.
REQ-002 SHALL have parameter MD_TIMEOUT, default 64, the maximum number of BUSY cycles before a forced multdiv completion.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_instr  in  32  fetched instruction.
REQ-006 SHALL have port load_use_stall  in  1  from the hazard unit's DX stall select.
REQ-007 SHALL have port branch_flush  in  1  taken branch, jump or bex resolved in X.
REQ-008 SHALL have port x_error  in  1  ALU overflow flag of the instruction in X.
REQ-009 SHALL have port md_rdy  in  1  multdiv result valid.
REQ-010 SHALL have port md_exception  in  1  multdiv error, qualified by md_rdy.
REQ-011 SHALL have ports fd_instr, dx_instr, xm_instr, wb_instr  out  32 each  stage instruction latches.
REQ-012 SHALL have ports xm_err, wb_err  out  1 each  stage error-flag latches.
REQ-013 SHALL have port pc_en  out  1  PC register write enable.
REQ-014 SHALL have port md_start  out  1  one-cycle multdiv start pulse.
REQ-015 SHALL have port md_busy  out  1  high while the FSM is in BUSY.

Function
REQ-016 Normal advance SHALL be: fd<=imem_instr, dx<=fd, xm<=dx, wb<=xm, xm_err<=x_error, wb_err<=xm_err, pc_en=1.
REQ-017 Load-use stall (load_use_stall=1, no flush, FSM IDLE) SHALL hold PC/FD (pc_en=0), load dx<=NOP_INSTR, and advance XM/WB normally.
REQ-018 Flush (branch_flush=1, FSM IDLE) SHALL load fd<=NOP_INSTR and dx<=NOP_INSTR with pc_en=1, advance XM/WB, and override load_use_stall in the same cycle.
REQ-019 A mul/div is opcode 5'd0 with ALU op 5'd6 or 5'd7 in dx_instr.
REQ-020 The FSM SHALL have states IDLE and BUSY.
REQ-021 IDLE with a mul/div in DX SHALL pulse md_start for exactly one cycle, go to BUSY, freeze PC/FD/DX, load xm<=NOP_INSTR with xm_err<=0, and advance WB.
REQ-022 BUSY without md_rdy SHALL keep PC/FD/DX frozen, keep inserting NOP into XM, and increment the 7-bit timeout counter.
REQ-023 BUSY with md_rdy SHALL perform a normal advance with xm_err<=md_exception and return to IDLE.
REQ-024 BUSY with counter==MD_TIMEOUT-1 and no md_rdy SHALL force the advance with xm_err<=1 and return to IDLE.
REQ-025 branch_flush and load_use_stall SHALL be ignored while BUSY.
REQ-026 A second mul/div arriving in DX on the completion advance SHALL start a new operation on the next cycle; no stale retrigger is allowed.
REQ-027 The counter SHALL clear on entry to BUSY.
REQ-028 md_busy SHALL equal (state==BUSY).
REQ-029 pc_en and md_start SHALL be combinational from state and inputs; all latches SHALL update in the same edge as the decision.

Reset
REQ-030 reset_n low SHALL asynchronously set all four instruction latches to NOP_INSTR, xm_err/wb_err=0, FSM=IDLE, counter=0, md_start=0.
REQ-031 pc_en SHALL be 1 after reset release.
REQ-032 Reset asserted during BUSY SHALL abandon the operation; no md_start is issued until a new mul/div reaches DX.

Configuration
REQ-033 With MULTDIV_EN defined, the FSM, counter, md_start and md_busy SHALL behave as above.
REQ-034 With MULTDIV_EN undefined, mul/div SHALL NOT be decoded, the FSM and counter SHALL be absent, md_start=md_busy=0, md_rdy/md_exception SHALL be ignored, and the ports SHALL remain present.

Structure
REQ-035 Shared package pipe_pkg SHALL hold the opcode constants (ALU 0, addi 5, jal 3, jr 4, sw 7, lw 8, setx 21, bex 22), ALU ops MUL 6 and DIV 7, the default NOP, and the FSM state enum.
REQ-036 One sub-module, pipe_latch, SHALL be used: a 32-bit register with enable and bubble-load input, instantiated four times.

Verification
REQ-037 Reset mid-stream: reset_n low for 1 cycle -> all *_instr=32'h0, errs=0, md_busy=0 immediately, without waiting for a clock edge.
REQ-038 Load-use stall: lw r3 in DX, load_use_stall=1 for 1 cycle -> fd held, dx=0, xm=lw, pc_en=0; next cycle normal advance.
REQ-039 Flush with simultaneous stall: branch_flush=1 and load_use_stall=1 -> fd=0, dx=0, pc_en=1.
REQ-040 Multdiv: mul in DX, md_rdy after 5 cycles with md_exception=1 -> md_start high 1 cycle, md_busy for 5 cycles, xm=mul, xm_err=1, wb_err=1 one cycle later.
REQ-041 Timeout: div in DX, md_rdy never asserted, MD_TIMEOUT=8 -> forced advance after 8 BUSY cycles with xm_err=1; branch_flush pulsed during BUSY has no effect.
REQ-042 Back-to-back: mul followed immediately by div -> two md_start pulses, each on the cycle after the instruction reaches DX in IDLE.
